serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be legal for WIDTH >= 2.
REQ-002 i_clock  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 i_reset_n  input  1  reset, asynchronous assert, active-low; state SHALL be cleared immediately on assertion, independent of i_clock.
REQ-004 i_valid  input  1  operands present on i_minuend/i_subtrahend.
REQ-005 o_ready  output  1  block can accept operands.
REQ-006 i_minuend  input  WIDTH  unsigned minuend.
REQ-007 i_subtrahend  input  WIDTH  unsigned subtrahend.
REQ-008 o_valid  output  1  result available.
REQ-009 i_ready  input  1  consumer accepts result.
REQ-010 o_difference  output  WIDTH  minuend minus subtrahend, modulo 2^WIDTH.
REQ-011 o_borrow  output  1  1 when minuend < subtrahend (unsigned).
REQ-012 o_overflow  output  1  signed overflow; present only under SERIAL_SUBTRACTOR_OVERFLOW_EN.

Function
REQ-013 FSM states IDLE, RUN and DONE SHALL be the only states.
REQ-014 o_ready SHALL be 1 exactly in IDLE; o_valid SHALL be 1 exactly in DONE.
REQ-015 IDLE with i_valid=1 at an edge SHALL latch both operands, clear borrow, clear bit counter, and go to RUN; i_valid=0 SHALL keep IDLE.
REQ-016 RUN SHALL process one bit per cycle, LSB first: diff = a ^ b ^ borrow_in; borrow_out = (~a & b) | (~(a ^ b) & borrow_in).
REQ-017 Each RUN cycle SHALL shift the diff bit into the result register from the MSB end and register borrow_out.
REQ-018 RUN SHALL last exactly WIDTH cycles; o_valid SHALL rise WIDTH edges after the accepting edge.
REQ-019 Bit counter SHALL be $clog2(WIDTH+1) bits and SHALL not wrap within an operation.
REQ-020 DONE with i_ready=1 at an edge SHALL return to IDLE; i_ready=0 SHALL hold DONE indefinitely.
REQ-021 o_difference, o_borrow and o_overflow SHALL be stable throughout DONE.
REQ-022 After leaving DONE, the three outputs SHALL hold the last result until the next DONE.
REQ-023 Operand inputs SHALL be ignored outside the accepting IDLE edge.
REQ-024 i_valid outside IDLE SHALL have no effect, and a pending i_valid SHALL be accepted on the first IDLE edge.
REQ-025 Minimum operation period SHALL be WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE with i_ready=1).

Reset
REQ-026 Reset asserted SHALL force state IDLE, o_ready=1, o_valid=0, o_difference=0, o_borrow=0, o_overflow=0, and clear counter and shift registers.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no result delivered.
REQ-028 The first accept SHALL be possible on the first rising edge after deassertion.

Configuration
REQ-029 With SERIAL_SUBTRACTOR_OVERFLOW_EN defined, o_overflow SHALL exist and equal (a_msb != b_msb) && (diff_msb != a_msb), captured on the final RUN cycle.
REQ-030 Without SERIAL_SUBTRACTOR_OVERFLOW_EN, port o_overflow and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package subtractor_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-032 The per-bit logic SHALL be a combinational sub-module full_subtractor (ports i_minuend, i_subtrahend, i_borrow, o_difference, o_borrow), instantiated once.

Verification
REQ-033 WIDTH=8, 5 - 3 -> o_difference=2, o_borrow=0, o_valid 8 edges after accept.
REQ-034 WIDTH=8, 3 - 5 -> o_difference=254, o_borrow=1; 0 - 0 -> 0, o_borrow=0.
REQ-035 WIDTH=8 with macro defined: 0x80 - 0x01 -> 0x7F, o_borrow=0, o_overflow=1; 0x7F - 0xFF -> 0x80, o_borrow=1, o_overflow=1.
REQ-036 i_ready held 0 for 5 cycles in DONE -> o_valid stays 1, outputs unchanged, o_ready=0; i_valid pulses during RUN are ignored.
REQ-037 Reset asserted in RUN cycle 3 -> immediate IDLE, o_valid=0, outputs 0; the next accept yields a correct result.
REQ-038 WIDTH=4, exhaustive 256 operand pairs back-to-back -> {o_borrow, o_difference} equals the 5-bit two's-complement of x - y for every pair.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// subtractor_pkg: shared types and constants for the bit-serial subtractor.
// Holds the control FSM state encoding, the default operand width and a
// helper that sizes the bit counter.

package subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // The bit counter must be able to hold the value WIDTH itself so it never wraps
    function automatic int counter_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result handshake bundle for serial_subtractor.
// The slave modport is the subtractor's view, the master modport is the
// view of whoever supplies operands and consumes results.
// o_overflow exists only when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.

interface serial_subtractor_if
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_minuend;
    logic [WIDTH-1:0] i_subtrahend;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_difference;
    logic             o_borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             o_overflow;
`endif

    modport slave (
        input  i_valid, i_minuend, i_subtrahend, i_ready,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        output o_overflow,
`endif
        output o_ready, o_valid, o_difference, o_borrow
    );

    modport master (
        output i_valid, i_minuend, i_subtrahend, i_ready,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        input  o_overflow,
`endif
        input  o_ready, o_valid, o_difference, o_borrow
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit combinational subtract stage (a - b - borrow_in).

module full_subtractor (
    input  logic i_minuend,
    input  logic i_subtrahend,
    input  logic i_borrow,
    output logic o_difference,
    output logic o_borrow
);

    // Difference is the parity of the three inputs; a borrow is needed when
    // b exceeds a, or when a equals b and a borrow is already pending
    always_comb begin
        o_difference = i_minuend ^ i_subtrahend ^ i_borrow;
        o_borrow     = (~i_minuend & i_subtrahend) | (~(i_minuend ^ i_subtrahend) & i_borrow);
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per clock, LSB first.
// Operands are accepted in IDLE, WIDTH cycles are spent in RUN, and the result
// is presented in DONE until the consumer takes it. The result registers keep
// the last answer until the next operation completes.
// Optional feature: define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the o_overflow
// (signed overflow) output and its capture logic.

module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    serial_subtractor_if.slave bus
);

    localparam int                CNT_W    = counter_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;

    // acc_reg starts as the minuend and, as bits are consumed from the LSB,
    // the difference bits are shifted in from the MSB end; after WIDTH
    // cycles it holds the complete difference.
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] sub_reg;
    logic             borrow_reg;
    logic [CNT_W-1:0] bit_cnt;

    logic [WIDTH-1:0] diff_reg;
    logic             borrow_out_reg;

    logic             bit_diff;
    logic             bit_borrow;
    logic             accept;
    logic             last_bit;
    logic             ready_int;
    logic             valid_int;

    full_subtractor u_bit (
        .i_minuend    (acc_reg[0]),
        .i_subtrahend (sub_reg[0]),
        .i_borrow     (borrow_reg),
        .o_difference (bit_diff),
        .o_borrow     (bit_borrow)
    );

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        next_state = state;
        ready_int  = 1'b0;
        valid_int  = 1'b0;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (bus.i_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (bit_cnt == LAST_BIT) begin
                    last_bit   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                valid_int = 1'b1;
                if (bus.i_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand load on accept, then one bit of subtraction per RUN cycle
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_reg    <= '0;
            sub_reg    <= '0;
            borrow_reg <= 1'b0;
            bit_cnt    <= '0;
        end else if (accept) begin
            acc_reg    <= bus.i_minuend;
            sub_reg    <= bus.i_subtrahend;
            borrow_reg <= 1'b0;
            bit_cnt    <= '0;
        end else if (state == RUN) begin
            acc_reg    <= {bit_diff, acc_reg[WIDTH-1:1]};
            sub_reg    <= {1'b0, sub_reg[WIDTH-1:1]};
            borrow_reg <= bit_borrow;
            bit_cnt    <= bit_cnt + CNT_W'(1);
        end
    end

    // Result capture on the final RUN cycle; held until the next completion
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
        end else if (last_bit) begin
            diff_reg       <= {bit_diff, acc_reg[WIDTH-1:1]};
            borrow_out_reg <= bit_borrow;
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic overflow_reg;

    // On the final cycle acc_reg[0]/sub_reg[0] are the operand sign bits and
    // bit_diff is the result sign bit
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overflow_reg <= 1'b0;
        end else if (last_bit) begin
            overflow_reg <= (acc_reg[0] != sub_reg[0]) && (bit_diff != acc_reg[0]);
        end
    end

    assign bus.o_overflow = overflow_reg;
`endif

    assign bus.o_ready      = ready_int;
    assign bus.o_valid      = valid_int;
    assign bus.o_difference = diff_reg;
    assign bus.o_borrow     = borrow_out_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor.
// An 8-bit instance covers reset, directed vectors, DONE back-pressure,
// ignored mid-run valids and reset mid-run; a 4-bit instance walks every
// operand pair back-to-back.

module tb_serial_subtractor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus8.slave)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus4.slave)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic startOp8(input logic [7:0] a, input logic [7:0] b);
        bus8.i_valid      = 1'b1;
        bus8.i_minuend    = a;
        bus8.i_subtrahend = b;
        @(negedge clk);
        bus8.i_valid      = 1'b0;
        bus8.i_minuend    = 8'hA5;
        bus8.i_subtrahend = 8'h3C;
    endtask

    task automatic waitDone8(input bit pulse, output int lat);
        lat = 0;
        while (bus8.o_valid !== 1'b1 && lat < 50) begin
            if (pulse) begin
                bus8.i_valid      = (lat < 6) && (lat % 2 == 0);
                bus8.i_minuend    = 8'hFF;
                bus8.i_subtrahend = 8'h01;
            end
            @(negedge clk);
            lat++;
        end
        bus8.i_valid = 1'b0;
    endtask

    task automatic checkResult8(input string tag, input vec_t v);
        checkOutput({tag, "_diff"}, bus8.o_difference, v.diff);
        checkOutput({tag, "_borrow"}, bus8.o_borrow, v.borrow);
        checkOutput({tag, "_ready"}, bus8.o_ready, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        checkOutput({tag, "_ovf"}, bus8.o_overflow, v.ovf);
`endif
    endtask

    task automatic release8(input string tag);
        bus8.i_ready = 1'b1;
        @(negedge clk);
        bus8.i_ready = 1'b0;
        checkOutput({tag, "_idle_ready"}, bus8.o_ready, 1'b1);
        checkOutput({tag, "_idle_valid"}, bus8.o_valid, 1'b0);
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        int lat;
        startOp8(v.a, v.b);
        waitDone8(1'b0, lat);
        checkOutput({tag, "_latency"}, lat, 8);
        checkResult8(tag, v);
        release8(tag);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;

        vecs[0] = '{8'd5,   8'd3,   8'd2,   1'b0, 1'b0};
        vecs[1] = '{8'd3,   8'd5,   8'd254, 1'b1, 1'b0};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
        vecs[3] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
        vecs[4] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
        vecs[5] = '{8'd200, 8'd100, 8'd100, 1'b0, 1'b1};
        vecs[6] = '{8'd9,   8'd4,   8'd5,   1'b0, 1'b0};
        vecs[7] = '{8'd100, 8'd200, 8'd156, 1'b1, 1'b1};

        bus8.i_valid = 1'b0; bus8.i_ready = 1'b0;
        bus8.i_minuend = '0; bus8.i_subtrahend = '0;
        bus4.i_valid = 1'b0; bus4.i_ready = 1'b1;
        bus4.i_minuend = '0; bus4.i_subtrahend = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", bus8.o_ready, 1'b1);
        checkOutput("rst_valid", bus8.o_valid, 1'b0);
        checkOutput("rst_diff", bus8.o_difference, 8'd0);
        checkOutput("rst_borrow", bus8.o_borrow, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        checkOutput("rst_ovf", bus8.o_overflow, 1'b0);
`endif
        rst_n = 1'b1;

        // Directed vectors; the first is accepted on the first edge after reset
        applyStimulus("v5m3", vecs[0]);
        applyStimulus("v3m5", vecs[1]);
        applyStimulus("v0m0", vecs[2]);
        applyStimulus("v80m01", vecs[3]);
        applyStimulus("v7Fm FF", vecs[4]);

        // Mid-run valid pulses ignored, then DONE held by back-pressure
        startOp8(vecs[5].a, vecs[5].b);
        waitDone8(1'b1, lat);
        checkOutput("hold_latency", lat, 8);
        checkResult8("hold", vecs[5]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", bus8.o_valid, 1'b1);
            checkOutput("hold_ready", bus8.o_ready, 1'b0);
            checkOutput("hold_diff", bus8.o_difference, vecs[5].diff);
            checkOutput("hold_borrow", bus8.o_borrow, vecs[5].borrow);
        end

        // Valid already pending as DONE is released: accepted on first IDLE edge
        bus8.i_ready      = 1'b1;
        bus8.i_valid      = 1'b1;
        bus8.i_minuend    = vecs[6].a;
        bus8.i_subtrahend = vecs[6].b;
        @(negedge clk);
        bus8.i_ready = 1'b0;
        checkOutput("pend_ready", bus8.o_ready, 1'b1);
        checkOutput("pend_valid", bus8.o_valid, 1'b0);
        checkOutput("keep_diff", bus8.o_difference, vecs[5].diff);
        @(negedge clk);
        bus8.i_valid      = 1'b0;
        bus8.i_minuend    = 8'hA5;
        bus8.i_subtrahend = 8'h3C;
        checkOutput("pend_run", bus8.o_ready, 1'b0);
        waitDone8(1'b0, lat);
        checkOutput("pend_latency", lat, 8);
        checkResult8("pend", vecs[6]);
        release8("pend");

        // Reset asserted in the third RUN cycle
        startOp8(vecs[7].a, vecs[7].b);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", bus8.o_ready, 1'b1);
        checkOutput("abort_valid", bus8.o_valid, 1'b0);
        checkOutput("abort_diff", bus8.o_difference, 8'd0);
        checkOutput("abort_borrow", bus8.o_borrow, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        checkOutput("abort_ovf", bus8.o_overflow, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after_rst", vecs[7]);

        // 4-bit instance: every operand pair back-to-back
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                bus4.i_valid      = 1'b1;
                bus4.i_minuend    = 4'(x);
                bus4.i_subtrahend = 4'(y);
                @(negedge clk);
                bus4.i_valid      = 1'b0;
                lat = 0;
                while (bus4.o_valid !== 1'b1 && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                checkOutput("ex4", {bus4.o_borrow, bus4.o_difference}, (x - y) & 31);
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
